// File: rtl/mem_multiport.sv
// Shared word RAM for NUM_PORTS requesters behind a round-robin arbiter, one transaction in flight.
// Optional byte-enable write port i_wstrb is enabled with `define MEM_WSTRB_EN.
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module mem_multiport #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 256,
  parameter int NUM_PORTS     = 2,
  parameter int LATENCY       = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               i_valid,
  output logic [NUM_PORTS-1:0]               o_ready,
  input  logic [NUM_PORTS-1:0]               i_cmd,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    i_data,
  input  logic [NUM_PORTS-1:0]               i_res_ready,
`ifdef MEM_WSTRB_EN
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] i_wstrb,
`endif
  output logic [NUM_PORTS-1:0]               o_res_valid,
  output logic [DATA_WIDTH-1:0]              o_data
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int OFF = (SW > 1) ? $clog2(SW) : 0;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           rr_q;
  logic [PW-1:0]           cand_id;
  logic [PW-1:0]           grant_id;
  logic                    grant_found;
  logic                    accept;
  logic                    hs;
  logic [CW-1:0]           cnt_q;

  logic                    g_cmd;
  logic [IW-1:0]           g_idx;
  logic [DATA_WIDTH-1:0]   g_wdata;
  logic [SW-1:0]           g_strb;

  logic [PW-1:0]           port_p1;
  logic [DATA_WIDTH-1:0]   rdata_p1;
  logic                    vld_p1;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Arbitration: first requester at or after the rr pointer, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_id     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_id = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (!grant_found && i_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  assign accept  = (state_q == IDLE) && grant_found;
  assign o_ready = accept ? (NUM_PORTS'(1) << grant_id) : '0;

  assign g_cmd   = i_cmd[grant_id];
  assign g_idx   = i_address[int'(grant_id)*ADDRESS_WIDTH + OFF +: IW];
  assign g_wdata = i_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
`ifdef MEM_WSTRB_EN
  assign g_strb  = i_wstrb[int'(grant_id)*SW +: SW];
`else
  assign g_strb  = '1;
`endif

  // Response handshake only counts on the port that owns the transaction
  assign hs          = vld_p1 && i_res_ready[port_p1];
  assign o_res_valid = vld_p1 ? (NUM_PORTS'(1) << port_p1) : '0;
  assign o_data      = rdata_p1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: capture transaction at accept, raise valid one cycle into RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      cnt_q    <= '0;
      port_p1  <= '0;
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= (state_q == RESP) && !hs;
      if (accept) begin
        rr_q     <= PW'((int'(grant_id) + 1) % NUM_PORTS);
        port_p1  <= grant_id;
        cnt_q    <= WAIT_INIT;
        rdata_p1 <= (g_cmd == `MEM_CMD_READ) ? mem[g_idx] : '0;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // RAM keeps its contents across reset; a write on a reset cycle is not accepted
  always_ff @(posedge clk) begin
    if (!reset && accept && (g_cmd == `MEM_CMD_WRITE)) begin
      for (int b = 0; b < SW; b++) begin
        if (g_strb[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_multiport.sv
// Scoreboard bench for mem_multiport: directed scenarios plus randomized two-port traffic.
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module tb_mem_multiport;
  localparam int DW = 32, AW = 32, DEPTH = 16, NP = 2, LAT = 2, SW = DW / 8;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0] i_valid, o_ready, i_cmd, i_res_ready, o_res_valid;
  logic [NP*AW-1:0] i_address;
  logic [NP*DW-1:0] i_data;
  logic [DW-1:0] o_data;
`ifdef MEM_WSTRB_EN
  logic [NP*SW-1:0] i_wstrb;
`endif

  mem_multiport #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .NUM_PORTS(NP),
                  .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_cmd(i_cmd),
    .i_address(i_address), .i_data(i_data), .i_res_ready(i_res_ready),
`ifdef MEM_WSTRB_EN
    .i_wstrb(i_wstrb),
`endif
    .o_res_valid(o_res_valid), .o_data(o_data));

  always #5 clk = ~clk;

  typedef struct { int port; logic [DW-1:0] data; int due; } exp_t;

  int cyc = 0;
  int vectors = 0, errors = 0;
  int rr_m = 0;
  int resp_count = 0;
  int acc_cnt [NP];
  int snap [NP];
  exp_t sb [$];
  int grant_log [$];
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] last_data;

  logic [NP-1:0] m_rdy, m_rv;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_word;
  logic [SW-1:0] m_strb;
  int m_p, m_idx;
  exp_t m_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [DW-1:0] got, logic [DW-1:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // Reference model: one transaction at a time, round-robin from the last winner + 1
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      rr_m = 0;
    end else begin
      m_rdy = '0;
      if (sb.size() == 0)
        for (int i = 0; i < NP; i++)
          if (m_rdy == '0 && i_valid[(rr_m + i) % NP]) m_rdy[(rr_m + i) % NP] = 1'b1;
      check("o_ready", DW'(o_ready), DW'(m_rdy));
      m_rv = '0;
      if (sb.size() != 0 && cyc >= sb[0].due) m_rv[sb[0].port] = 1'b1;
      check("o_res_valid", DW'(o_res_valid), DW'(m_rv));
      if (m_rv != '0) begin
        check("o_data", o_data, sb[0].data);
        if (i_res_ready[sb[0].port]) begin
          last_data = o_data;
          resp_count++;
          void'(sb.pop_front());
        end
      end
      for (int p = 0; p < NP; p++)
        if (o_ready[p] && i_valid[p]) acc_cnt[p]++;
      if (m_rdy != '0) begin
        m_p = 0;
        for (int p = 0; p < NP; p++) if (m_rdy[p]) m_p = p;
        grant_log.push_back(m_p);
        rr_m = (m_p + 1) % NP;
        m_addr = i_address[m_p*AW +: AW];
        m_idx = int'((m_addr >> 2) % DEPTH);
`ifdef MEM_WSTRB_EN
        m_strb = i_wstrb[m_p*SW +: SW];
`else
        m_strb = '1;
`endif
        m_e.port = m_p;
        m_e.due = cyc + 1 + LAT;
        if (i_cmd[m_p] == `MEM_CMD_WRITE) begin
          m_word = mdl_mem[m_idx];
          for (int b = 0; b < SW; b++)
            if (m_strb[b]) m_word[b*8 +: 8] = i_data[m_p*DW + b*8 +: 8];
          mdl_mem[m_idx] = m_word;
          m_e.data = '0;
        end else begin
          m_e.data = mdl_mem[m_idx];
        end
        sb.push_back(m_e);
      end
    end
  end

  task automatic set_req(int p, logic cmd, logic [AW-1:0] addr, logic [DW-1:0] data,
                         logic [SW-1:0] strb);
    i_valid[p] = 1'b1;
    i_cmd[p] = cmd;
    i_address[p*AW +: AW] = addr;
    i_data[p*DW +: DW] = data;
`ifdef MEM_WSTRB_EN
    i_wstrb[p*SW +: SW] = strb;
`else
    if (strb == '0) i_data[p*DW +: DW] = data;
`endif
    snap[p] = acc_cnt[p];
  endtask

  task automatic wait_acc(int p);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (acc_cnt[p] != snap[p]) begin
        i_valid[p] = 1'b0;
        return;
      end
    end
    vectors++; errors++;
    $display("FAIL accept_timeout: port %0d got no accept, expected one within 40 cycles", p);
    i_valid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) return;
    end
    vectors++; errors++;
    $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
  endtask

  task automatic do_txn(int p, logic cmd, logic [AW-1:0] addr, logic [DW-1:0] data,
                        logic [SW-1:0] strb);
    set_req(p, cmd, addr, data, strb);
    wait_acc(p);
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    i_valid = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int rc;
    reset = 1'b1;
    i_valid = '0; i_cmd = '0; i_address = '0; i_data = '0; i_res_ready = '1;
`ifdef MEM_WSTRB_EN
    i_wstrb = '1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_o_ready", DW'(o_ready), '0);
    check("rst_o_res_valid", DW'(o_res_valid), '0);
    check("rst_o_data", o_data, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++)
      do_txn(0, `MEM_CMD_WRITE, AW'(w * 4), 32'hA500_0000 + DW'(w), '1);

    // Write then read back the same word
    do_txn(0, `MEM_CMD_WRITE, 32'h8, 32'hDEAD_BEEF, '1);
    check("t1_write_ack", last_data, 32'h0);
    do_txn(0, `MEM_CMD_READ, 32'h8, '0, '1);
    check("t1_read", last_data, 32'hDEAD_BEEF);

    // Address wrap and byte offset
    do_txn(1, `MEM_CMD_WRITE, 32'h44, 32'h1234_5678, '1);
    do_txn(0, `MEM_CMD_READ, 32'h04, '0, '1);
    check("t4_wrap", last_data, 32'h1234_5678);
    do_txn(1, `MEM_CMD_READ, 32'h05, '0, '1);
    check("t4_offset", last_data, 32'h1234_5678);

    // Both ports requesting continuously after reset
    pulse_reset();
    grant_log.delete();
    set_req(0, `MEM_CMD_READ, AW'($urandom_range(0, 255)), '0, '1);
    set_req(1, `MEM_CMD_READ, AW'($urandom_range(0, 255)), '0, '1);
    for (int k = 0; k < 200 && grant_log.size() < 8; k++) begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++)
        if (acc_cnt[p] != snap[p]) set_req(p, `MEM_CMD_READ, AW'($urandom_range(0, 255)), '0, '1);
    end
    i_valid = '0;
    wait_idle();
    check("t2_grant_count", DW'(grant_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) check("t2_grant_order", DW'(grant_log[i]), DW'(i % 2));

    // Backpressure on port 1 while port 0 waits
    i_res_ready = 2'b01;
    set_req(1, `MEM_CMD_READ, 32'h10, '0, '1);
    wait_acc(1);
    set_req(0, `MEM_CMD_READ, 32'h14, '0, '1);
    repeat (LAT + 5) @(posedge clk);
    @(negedge clk);
    check("t3_hold_valid", DW'(o_res_valid), 32'h2);
    check("t3_hold_data", o_data, 32'hA500_0004);
    check("t3_hold_ready", DW'(o_ready), 32'h0);
    @(posedge clk); #1;
    i_res_ready = '1;
    wait_acc(0);
    wait_idle();
    check("t3_port0_data", last_data, 32'hA500_0005);

    // Reset in WAIT of a read: no response ever
    set_req(0, `MEM_CMD_READ, 32'h8, '0, '1);
    wait_acc(0);
    rc = resp_count;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_valid_after_reset", DW'(o_res_valid), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_response", DW'(resp_count), DW'(rc));

    // Reset in WAIT of a write: data still lands in RAM
    set_req(1, `MEM_CMD_WRITE, 32'h20, 32'h5555_AAAA, '1);
    wait_acc(1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_txn(0, `MEM_CMD_READ, 32'h20, '0, '1);
    check("t5_write_kept", last_data, 32'h5555_AAAA);

`ifdef MEM_WSTRB_EN
    do_txn(0, `MEM_CMD_WRITE, 32'h0, 32'hFFFF_FFFF, 4'hF);
    do_txn(0, `MEM_CMD_WRITE, 32'h0, 32'h0000_0000, 4'b0101);
    do_txn(1, `MEM_CMD_READ, 32'h0, '0, 4'b0000);
    check("t6_strobe", last_data, 32'hFF00_FF00);
`endif

    // Randomized traffic on both ports with random response backpressure
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      i_res_ready = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        if (i_valid[p] && acc_cnt[p] != snap[p]) i_valid[p] = 1'b0;
        if (!i_valid[p] && $urandom_range(0, 2) == 0)
          set_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom),
                  SW'($urandom));
      end
    end
    i_valid = '0;
    i_res_ready = '1;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
